// File: rtl/cdc_xfer_pkg.sv
// Shared types and counter sizing for the CDC transfer arbiter.
// The state enum includes ERR so the type is the same whether or not CDC_XFER_TIMEOUT_EN is defined.
package cdc_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_ACK = 2'd2,
    ERR      = 2'd3
  } xfer_state_t;

  localparam int CNT_W_MIN = 1;

  // Bits needed to hold 0..max_val; a zero-width counter is never allowed.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < CNT_W_MIN) ? CNT_W_MIN : w;
  endfunction

endpackage

// File: rtl/cdc_xfer_arbiter_rr.sv
// Round-robin pick for cdc_xfer_arbiter. The first valid requester at or after rr_ptr wins,
// wrapping modulo NREQ. This block is purely combinational.
module cdc_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] cand_idx [NREQ];
  logic [NREQ-1:0] cand_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDW'((int'(rr_ptr) + gi) % NREQ);
      assign cand_vld[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Scan from farthest to nearest so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_idx = cand_idx[k];
        grant_any = 1'b1;
      end
    end
    grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Source-side controller that shares one CDC data channel between NREQ requesters using a 2-phase toggle handshake.
// Defining CDC_XFER_TIMEOUT_EN adds an ack timeout, a sticky tmo_err output, a tmo_clr input and an ERR state.
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              src_clk,
  input  logic              src_rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic              ack_tgl_sync,
  output logic [WIDTH-1:0]  xfer_data,
  output logic [IDW-1:0]    xfer_id,
  output logic              req_tgl,
  output logic              busy,
  output logic              done_pulse
`ifdef CDC_XFER_TIMEOUT_EN
  ,
  output logic              tmo_err,
  input  logic              tmo_clr
`endif
);

  localparam int SCW = cnt_width(SETTLE_CYC);

  generate
    if (NREQ < 2) begin : g_bad_nreq
      $error("cdc_xfer_arbiter: NREQ must be at least 2");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("cdc_xfer_arbiter: SETTLE_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_tmo
      $error("cdc_xfer_arbiter: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  xfer_state_t    state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [SCW-1:0] settle_cnt_reg;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [IDW-1:0] rr_ptr_next;
  logic [WIDTH-1:0] req_word [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_word
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  cdc_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready   = (state_reg == IDLE) ? grant : '0;
  assign busy        = (state_reg != IDLE);
  assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef CDC_XFER_TIMEOUT_EN
  localparam int TCW = cnt_width(TIMEOUT_CYC);
  logic [TCW-1:0] tmo_cnt_reg;
`endif

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      settle_cnt_reg <= '0;
      xfer_data      <= '0;
      xfer_id        <= '0;
      req_tgl        <= 1'b0;
      done_pulse     <= 1'b0;
`ifdef CDC_XFER_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      tmo_err        <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            xfer_data      <= req_word[grant_idx];
            xfer_id        <= grant_idx;
            rr_ptr_reg     <= rr_ptr_next;
            settle_cnt_reg <= SCW'(SETTLE_CYC);
            state_reg      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg - 1'b1;
          if (settle_cnt_reg == SCW'(1)) begin
            req_tgl   <= ~req_tgl;
            state_reg <= WAIT_ACK;
`ifdef CDC_XFER_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (ack_tgl_sync == req_tgl) begin
            done_pulse <= 1'b1;
            state_reg  <= IDLE;
          end
`ifdef CDC_XFER_TIMEOUT_EN
          else if (tmo_cnt_reg == TCW'(TIMEOUT_CYC - 1)) begin
            tmo_err   <= 1'b1;
            state_reg <= ERR;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        ERR: begin
`ifdef CDC_XFER_TIMEOUT_EN
          // Only leave once the channel is quiescent again, otherwise a stale ack would complete the next word.
          if (tmo_clr && (ack_tgl_sync == req_tgl)) begin
            tmo_err     <= 1'b0;
            tmo_cnt_reg <= '0;
            state_reg   <= IDLE;
          end
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed self-checking bench for cdc_xfer_arbiter; req_tgl is looped back to ack_tgl_sync through 3 flops.
// Define CDC_XFER_TIMEOUT_EN to also exercise the timeout path with TIMEOUT_CYC = 16.
module tb_cdc_xfer_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
`ifdef CDC_XFER_TIMEOUT_EN
  localparam int TMO   = 16;
`else
  localparam int TMO   = 1024;
`endif

  logic             src_clk;
  logic             src_rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic             ack_tgl_sync;
  logic [WIDTH-1:0] xfer_data;
  logic [1:0]       xfer_id;
  logic             req_tgl;
  logic             busy;
  logic             done_pulse;
  logic             tmo_err;
  logic             tmo_clr;

  logic [2:0] ack_dly;
  logic       ack_force;
  logic       ack_force_val;
  int         n_checks;
  int         n_fail;
  int         done_total;

  cdc_xfer_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .SETTLE_CYC(2), .TIMEOUT_CYC(TMO)
  ) dut (
    .src_clk      (src_clk),
    .src_rst      (src_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .ack_tgl_sync (ack_tgl_sync),
    .xfer_data    (xfer_data),
    .xfer_id      (xfer_id),
    .req_tgl      (req_tgl),
    .busy         (busy),
    .done_pulse   (done_pulse)
`ifdef CDC_XFER_TIMEOUT_EN
    ,
    .tmo_err      (tmo_err),
    .tmo_clr      (tmo_clr)
`endif
  );

`ifndef CDC_XFER_TIMEOUT_EN
  assign tmo_err = 1'b0;
`endif

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  // Destination-side model: resets together with the source side.
  always @(posedge src_clk or posedge src_rst) begin
    if (src_rst) ack_dly <= 3'b000;
    else         ack_dly <= {ack_dly[1:0], req_tgl};
  end
  assign ack_tgl_sync = ack_force ? ack_force_val : ack_dly[2];

  always @(posedge src_clk) begin
    if (done_pulse) done_total <= done_total + 1;
  end

  // Each step advances one rising edge and returns on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge src_clk);
      @(negedge src_clk);
    end
  endtask

  task automatic set_word(input int idx, input logic [WIDTH-1:0] v);
    req_data[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (done_pulse) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    src_rst   = 1'b1;
    req_valid = '0;
    tmo_clr   = 1'b0;
    ack_force = 1'b0;
    @(negedge src_clk);
    @(negedge src_clk);
    src_rst = 1'b0;
  endtask

  task automatic test_reset();
    src_rst   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tmo_clr   = 1'b0;
    ack_force = 1'b0;
    ack_force_val = 1'b0;
    @(negedge src_clk);
    n_checks++;
    if ({xfer_data, xfer_id, req_tgl, busy, done_pulse, tmo_err, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h id=%0d tgl=%b busy=%b done=%b tmo=%b ready=%b, want all 0",
               xfer_data, xfer_id, req_tgl, busy, done_pulse, tmo_err, req_ready);
    end
    @(negedge src_clk);
    src_rst = 1'b0;
    step(2);
    n_checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_valid: got ready=%b busy=%b, want 0000 0", req_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    set_word(2, 8'hA5);
    req_valid = 4'b0100;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step(1);
    req_valid = '0;
    n_checks++;
    if (xfer_data !== 8'hA5 || xfer_id !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: got data=%h id=%0d busy=%b want a5 2 1", xfer_data, xfer_id, busy);
    end
    step(1);
    n_checks++;
    if (req_tgl !== 1'b0) begin
      n_fail++; $display("FAIL single_tgl_early: got %b want 0 one cycle after accept", req_tgl);
    end
    step(1);
    n_checks++;
    if (req_tgl !== 1'b1) begin
      n_fail++; $display("FAIL single_tgl: got %b want 1 two cycles after accept", req_tgl);
    end
    step(3);
    n_checks++;
    if (done_pulse !== 1'b0 || ack_tgl_sync !== 1'b1) begin
      n_fail++; $display("FAIL single_pre_done: got done=%b ack=%b want 0 1", done_pulse, ack_tgl_sync);
    end
    step(1);
    n_checks++;
    if (done_pulse !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got done=%b busy=%b want 1 0", done_pulse, busy);
    end
    step(1);
    n_checks++;
    if (done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL single_done_width: got %b want 0", done_pulse);
    end
    ok = 1'b1;
    $display("test_single done (ok=%0d)", ok);
  endtask

  task automatic test_back_to_back();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int rises;
    int dones;
    logic prev_busy;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_word(i, 8'h10 + 8'(i));
    req_valid = 4'b1111;
    rises = 0;
    dones = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (done_pulse) dones++;
      if (busy && !prev_busy) begin
        if (rises < 6) begin
          n_checks++;
          if (xfer_id !== 2'(exp_order[rises]) || xfer_data !== 8'h10 + 8'(exp_order[rises])) begin
            n_fail++;
            $display("FAIL b2b_grant%0d: got id=%0d data=%h want id=%0d", rises, xfer_id, xfer_data, exp_order[rises]);
          end
        end
        rises++;
        if (rises == 6) req_valid = '0;
      end
      prev_busy = busy;
      if (rises >= 6 && !busy) break;
    end
    n_checks++;
    if (rises != 6 || dones != 6) begin
      n_fail++; $display("FAIL b2b_counts: got grants=%0d dones=%0d want 6 6", rises, dones);
    end
    $display("test_back_to_back done (grants=%0d dones=%0d)", rises, dones);
  endtask

  task automatic test_data_hold();
    bit ok;
    do_reset();
    set_word(0, 8'h3C);
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(3);
    set_word(0, 8'hFF);
    step(1);
    n_checks++;
    if (xfer_data !== 8'h3C || busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_wait_ack: got data=%h busy=%b want 3c 1", xfer_data, busy);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || xfer_data !== 8'h3C) begin
      n_fail++; $display("FAIL hold_after_done: got done_seen=%0d data=%h want 1 3c", ok, xfer_data);
    end
    set_word(1, 8'h77);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    n_checks++;
    if (xfer_data !== 8'h77 || xfer_id !== 2'd1) begin
      n_fail++; $display("FAIL hold_next_accept: got data=%h id=%0d want 77 1", xfer_data, xfer_id);
    end
    wait_done(ok);
    $display("test_data_hold done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_word(1, 8'h5A);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    ack_force = 1'b1;
    ack_force_val = 1'b0;
    step(3);
    n_checks++;
    if (busy !== 1'b1 || req_tgl !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got busy=%b tgl=%b want 1 1", busy, req_tgl);
    end
    src_rst = 1'b1;
    #1;
    n_checks++;
    if ({xfer_data, xfer_id, req_tgl, busy, done_pulse, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got data=%h id=%0d tgl=%b busy=%b done=%b ready=%b want all 0",
               xfer_data, xfer_id, req_tgl, busy, done_pulse, req_ready);
    end
    @(negedge src_clk);
    src_rst = 1'b0;
    ack_force = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL mid_rr_ptr: got ready=%b want 0001", req_ready);
    end
    step(1);
    req_valid = '0;
    wait_done(ok);
    $display("test_reset_mid done");
  endtask

  task automatic test_drop_valid();
    bit ok;
    do_reset();
    req_valid = 4'b0001;
    step(1);
    req_valid = 4'b1010;
    step(2);
    req_valid = 4'b1000;
    wait_done(ok);
    n_checks++;
    if (!ok || req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL drop_ready: got done_seen=%0d ready=%b want 1 1000", ok, req_ready);
    end
    step(1);
    req_valid = '0;
    n_checks++;
    if (xfer_id !== 2'd3) begin
      n_fail++; $display("FAIL drop_grant: got id=%0d want 3", xfer_id);
    end
    wait_done(ok);
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (!ok || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL drop_rr_wrap: got done_seen=%0d ready=%b want 1 0001", ok, req_ready);
    end
    req_valid = '0;
    $display("test_drop_valid done");
  endtask

`ifdef CDC_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int done_before;
    do_reset();
    ack_force = 1'b1;
    ack_force_val = 1'b0;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(2);
    done_before = done_total;
    step(14);
    n_checks++;
    if (tmo_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early: got %b want 0 after 14 wait cycles", tmo_err);
    end
    step(2);
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (tmo_err !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000 || done_total != done_before) begin
      n_fail++;
      $display("FAIL tmo_set: got tmo=%b busy=%b ready=%b dones=%0d want 1 1 0000 %0d",
               tmo_err, busy, req_ready, done_total, done_before);
    end
    req_valid = '0;
    tmo_clr = 1'b1;
    step(1);
    n_checks++;
    if (tmo_err !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL tmo_clr_mismatch: got tmo=%b busy=%b want 1 1", tmo_err, busy);
    end
    ack_force_val = 1'b1;
    step(1);
    tmo_clr = 1'b0;
    n_checks++;
    if (tmo_err !== 1'b0 || busy !== 1'b0 || done_pulse !== 1'b0) begin
      n_fail++; $display("FAIL tmo_clear: got tmo=%b busy=%b done=%b want 0 0 0", tmo_err, busy, done_pulse);
    end
    $display("test_timeout done");
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_total = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_data_hold();
    test_reset_mid();
    test_drop_valid();
`ifdef CDC_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
